// File: rtl/inst_encoder.sv
// RV32I program loader: encodes field-level requests and writes them to sequential words; write appears 1 cycle after accept.
// Backpressure: req_ready drops while memory is full or clear is asserted; out-of-range immediates are consumed without a write.
module inst_encoder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [4:0]           req_rd,
    input  logic [4:0]           req_rs1,
    input  logic [4:0]           req_rs2,
    input  logic [31:0]          req_imm,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [ADDR_BITS:0]   count,
    output logic                 full,
    output logic                 err
);

    localparam logic [ADDR_BITS:0] CAP = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_BEQ  = 3'd7;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state, state_next;
    logic [31:0] word;
    logic        imm_ok;
    logic        i_ok, b_ok;
    logic        accept, do_write;
    logic [31:0] wr_offset;

    assign full      = (count == CAP);
    assign req_ready = !full && !clear;
    assign accept    = req_valid && req_ready;
    assign do_write  = accept && imm_ok;
    assign mem_we    = (state == WRITE);
    assign wr_offset = 32'(count) << 2;

    // Signed-fit checks: all sign bits above the field must agree.
    assign i_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign b_ok = ((&req_imm[31:12]) | ~(|req_imm[31:12])) & ~req_imm[0];

    always_comb begin
        word   = '0;
        imm_ok = 1'b1;
        case (req_op)
            OP_LW: begin
                word   = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
                imm_ok = i_ok;
            end
            OP_SW: begin
                word   = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
                imm_ok = i_ok;
            end
            OP_ADDI: begin
                word   = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b0010011};
                imm_ok = i_ok;
            end
            OP_ADD: word = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
            OP_SUB: word = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
            OP_OR:  word = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, 7'b0110011};
            OP_AND: word = {7'b0000000, req_rs2, req_rs1, 3'b111, req_rd, 7'b0110011};
            OP_BEQ: begin
                word   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                          req_imm[4:1], req_imm[11], 7'b1100011};
                imm_ok = b_ok;
            end
            default: word = '0;
        endcase
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = do_write ? WRITE : IDLE;
            WRITE:   state_next = do_write ? WRITE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            if (clear) begin
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                if (imm_ok) begin
                    mem_addr  <= BASE_ADDR + wr_offset;
                    mem_wdata <= word;
                    count     <= count + ONE;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: driver pushes expected writes, negedge monitor pops and compares.
module tb_inst_encoder;

    localparam int          AB   = 2;
    localparam int          CAP  = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = '0;
    logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0]   req_imm = '0;
    logic          mem_we;
    logic [31:0]   mem_addr, mem_wdata;
    logic [AB:0]   count;
    logic          full, err;

    inst_encoder #(.ADDR_BITS(AB), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          checks = 0, errors = 0;
    wr_t         exp_q[$];
    int          m_count = 0;
    bit          m_err = 1'b0, m_we = 1'b0;
    logic [31:0] last_addr = BASE, last_wdata = '0;
    wr_t         got;

    int opc_tab[8] = '{3, 35, 19, 51, 51, 51, 51, 99};
    int f3_tab[8]  = '{2, 2, 0, 0, 0, 6, 7, 0};
    int bounds[10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 4096, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference encoder built from field weights and signed ranges.
    function automatic logic [31:0] model_word(input int op, input int rd, input int rs1,
                                               input int rs2, input logic [31:0] imm, output bit ok);
        longint s, u, w, base;
        s    = longint'($signed(imm));
        base = longint'(rs1) * (2 ** 15) + longint'(f3_tab[op]) * 4096 + opc_tab[op];
        w    = 0;
        ok   = 1'b1;
        if (op == 0 || op == 2) begin
            ok = (s >= -2048) && (s <= 2047);
            u  = ((s % 4096) + 4096) % 4096;
            w  = u * (2 ** 20) + base + longint'(rd) * 128;
        end else if (op == 1) begin
            ok = (s >= -2048) && (s <= 2047);
            u  = ((s % 4096) + 4096) % 4096;
            w  = (u / 32) * (2 ** 25) + longint'(rs2) * (2 ** 20) + base + (u % 32) * 128;
        end else if (op == 7) begin
            ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
            u  = ((s % 8192) + 8192) % 8192;
            w  = (u / 4096) * (longint'(2) ** 31) + ((u / 32) % 64) * (2 ** 25)
               + longint'(rs2) * (2 ** 20) + base + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128;
        end else begin
            w = (op == 4 ? 32 : 0) * (2 ** 25) + longint'(rs2) * (2 ** 20) + base + longint'(rd) * 128;
        end
        return 32'(w);
    endfunction

    task automatic step(input bit v, input int op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input bit clr, input bit use_want, input logic [31:0] want);
        bit          ok, acc;
        logic [31:0] w;
        req_valid = v;
        req_op    = 3'(op);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = imm;
        clear     = clr;
        w   = model_word(op, rd, rs1, rs2, imm, ok);
        if (use_want) w = want;
        acc = v && !clr && (m_count < CAP);
        @(posedge clk);
        m_we = 1'b0;
        if (clr) begin
            m_count = 0;
            m_err   = 1'b0;
        end else if (acc) begin
            if (ok) begin
                exp_q.push_back('{a: BASE + 32'(4 * m_count), d: w});
                m_count++;
                m_we = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        clear = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_err = 1'b0;
        m_we = 1'b0;
        last_addr = BASE;
        last_wdata = '0;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", 32'(count), 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);
        check("rst_req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        check("mem_we", mem_we, m_we);
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_wdata);
            end else begin
                got = exp_q.pop_front();
                check("mem_addr", mem_addr, got.a);
                check("mem_wdata", mem_wdata, got.d);
                last_addr  = got.a;
                last_wdata = got.d;
            end
        end else begin
            check("hold_addr", mem_addr, last_addr);
            check("hold_wdata", mem_wdata, last_wdata);
        end
        check("count", 32'(count), 32'(m_count));
        check("full", full, m_count == CAP);
        check("err", err, m_err);
        check("req_ready", req_ready, !clear && (m_count < CAP));
    end

    initial begin
        int op, sel;
        logic [31:0] imm;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed vectors with known encodings.
        step(1, 2, 1, 0, 0, 32'd5, 0, 1, 32'h00500093);
        step(1, 0, 2, 1, 0, 32'd8, 0, 1, 32'h0080A103);
        step(1, 1, 31, 1, 2, 32'd12, 0, 1, 32'h0020A623);
        idle(1);
        step(0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        step(1, 4, 3, 1, 2, 32'hDEAD_BEEF, 0, 1, 32'h402081B3);
        step(1, 7, 9, 1, 2, -32'sd8, 0, 1, 32'hFE208CE3);
        idle(1);
        step(1, 2, 1, 0, 0, 32'd2048, 0, 0, 32'h0);
        step(1, 7, 1, 1, 2, 32'd3, 0, 0, 32'h0);
        idle(1);
        step(0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0);

        // Fill to capacity with valid held; the fifth request must stall.
        for (int i = 0; i < 6; i++) step(1, 2, i + 1, 0, 0, 32'(i), 0, 0, 32'h0);
        step(1, 2, 5, 0, 0, 32'd4, 1, 0, 32'h0);
        step(1, 2, 5, 0, 0, 32'd4, 0, 0, 32'h0);
        idle(1);
        step(0, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0);

        // Reset in the middle of a back-to-back stream.
        step(1, 3, 4, 5, 6, 32'h0, 0, 0, 32'h0);
        step(1, 5, 7, 8, 9, 32'h0, 0, 0, 32'h0);
        do_reset();
        step(1, 6, 10, 11, 12, 32'h0, 0, 0, 32'h0);
        idle(1);

        for (int n = 0; n < 1500; n++) begin
            op  = $urandom_range(0, 7);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       imm = 32'(bounds[$urandom_range(0, 9)]);
                2:       imm = $urandom;
                default: imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            endcase
            step($urandom_range(0, 9) < 8, op, $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), imm, $urandom_range(0, 11) == 0, 0, 32'h0);
        end
        idle(2);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
